// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// Size encodings, FSM states and the split-access buffer layout.
package lsu_pkg;

  localparam int DW    = 32;
  localparam int ADDRW = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Everything the second half of a misaligned access needs, captured in the first cycle.
  typedef struct packed {
    logic [DW-1:0]    rdata;
    logic [7:0]       m8;
    logic [2*DW-1:0]  d64;
    logic [ADDRW-1:0] addr;
    logic [1:0]       off;
    logic [1:0]       size;
    logic             uns;
    logic             we;
  } split_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte mask and write data shifted into lanes, and read data
// shifted down and sign/zero-extended according to size.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      off_i,
  input  logic            uns_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [2*DW-1:0] r64_i,
  output logic [7:0]      m8_o,
  output logic [2*DW-1:0] d64_o,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] shifted;

  always_comb begin
    m8_o    = 8'(size_mask(size_i)) << off_i;
    d64_o   = {{DW{1'b0}}, wdata_i} << {off_i, 3'b000};
    shifted = DW'(r64_i >> {off_i, 3'b000});
    case (size_i)
      SZ_B:    rdata_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
      SZ_W:    rdata_o = shifted;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte-addressed requests to a word-addressed, byte-masked
// memory, splitting misaligned accesses into two back-to-back cycles.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [31:0]      req_addr_i,
  input  logic [DW-1:0]    req_wdata_i,
  output logic             rsp_valid_o,
  output logic [DW-1:0]    rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_mask_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i
);

  state_e           state_q, state_d;
  split_t           buf_q, buf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [ADDRW-1:0] last_addr_q, last_addr_d;
  logic [DW-1:0]    last_wdata_q, last_wdata_d;

  logic             in_second;
  logic [ADDRW-1:0] a_word;
  logic [1:0]       al_size, al_off;
  logic             al_uns;
  logic [2*DW-1:0]  r64;
  logic [7:0]       m8;
  logic [2*DW-1:0]  d64;
  logic [DW-1:0]    ext_rdata;
  logic             misaligned, err, mem_we;

  assign in_second = (state_q == SECOND);
  assign a_word    = req_addr_i[ADDRW+1:2];

  // In SECOND the aligner works on the buffered request so the load result spans both words.
  assign al_size = in_second ? buf_q.size : req_size_i;
  assign al_off  = in_second ? buf_q.off  : req_addr_i[1:0];
  assign al_uns  = in_second ? buf_q.uns  : req_unsigned_i;
  assign r64     = in_second ? {mem_rdata_i, buf_q.rdata} : {{DW{1'b0}}, mem_rdata_i};

  lsu_align u_align (
    .size_i  (al_size),
    .off_i   (al_off),
    .uns_i   (al_uns),
    .wdata_i (req_wdata_i),
    .r64_i   (r64),
    .m8_o    (m8),
    .d64_o   (d64),
    .rdata_o (ext_rdata)
  );

  assign misaligned = |m8[7:4];
  assign err = (req_size_i == 2'b11) || (|req_addr_i[31:ADDRW+2]) || (misaligned && (&a_word));

  // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    mem_mask_o  = 4'b0000;
    mem_addr_o  = last_addr_q;
    mem_wdata_o = last_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          mem_addr_o  = a_word;
          mem_mask_o  = m8[3:0];
          mem_wdata_o = d64[DW-1:0];
          mem_we      = req_we_i && !err;
          if (misaligned && !err) begin
            state_d = SECOND;
            buf_d   = '{rdata: mem_rdata_i, m8: m8, d64: d64, addr: a_word,
                        off: req_addr_i[1:0], size: req_size_i,
                        uns: req_unsigned_i, we: req_we_i};
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err;
            rsp_rdata_d = (err || req_we_i) ? '0 : ext_rdata;
          end
        end
      end
      SECOND: begin
        mem_addr_o  = buf_q.addr + ADDRW'(1);
        mem_mask_o  = buf_q.m8[7:4];
        mem_wdata_o = buf_q.d64[2*DW-1:DW];
        mem_we      = buf_q.we;
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = buf_q.we ? '0 : ext_rdata;
      end
      default: state_d = IDLE;
    endcase

    last_addr_d  = mem_addr_o;
    last_wdata_d = mem_wdata_o;
  end

  assign mem_we_o    = mem_we && rst_ni;
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

endmodule
